// File: rtl/bp_nonsynth_commit_filter.sv
// Debug-filtered commit strobe, commit counter and stall detector for the perf/finish monitor.
// Optional BP_NONSYNTH_COMMIT_WATCHDOG_EN: report the stall with the last forwarded PC and end sim.
module bp_nonsynth_commit_filter #(
   parameter int          vaddr_width_p = 39,
   parameter int          num_core_p    = 1,
   parameter int          stall_limit_p = 2**16,
   parameter logic [31:0] dret_instr_p  = 32'h7b200073,
   localparam int hart_w_lp  = (num_core_p == 1) ? 1 : $clog2(num_core_p),
   localparam int stall_w_lp = (stall_limit_p + 1 == 1) ? 1 : $clog2(stall_limit_p + 1)
)(
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic [hart_w_lp-1:0]     mhartid_i,
   input  logic                     commit_v_i,
   input  logic [vaddr_width_p-1:0] commit_pc_i,
   input  logic [31:0]              commit_instr_i,
   input  logic                     debug_enter_i,
   output logic                     commit_v_o,
   output logic                     is_debug_mode_o,
   output logic [63:0]              commit_cnt_o,
   output logic                     stall_o
);

   localparam logic [stall_w_lp-1:0] LIMIT = stall_w_lp'(stall_limit_p);

   typedef enum logic [1:0] {
      E_RUN,
      E_DEBUG,
      E_EXIT
   } state_e;

   state_e                r_state;
   state_e                w_state_nxt;
   logic                  r_commit_v;
   logic                  r_dbg;
   logic [63:0]           r_cnt;
   logic [stall_w_lp-1:0] r_scnt;
   logic [stall_w_lp-1:0] w_scnt_nxt;
   logic                  r_stall;
   logic                  w_is_dret;
   logic                  w_fwd;

   assign w_is_dret = (commit_instr_i == dret_instr_p);
   // A commit alongside the trap retired first, so RUN state alone decides
   assign w_fwd     = commit_v_i & (r_state == E_RUN);

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         E_RUN:   if (debug_enter_i) w_state_nxt = E_DEBUG;
         E_DEBUG: if (commit_v_i & w_is_dret) w_state_nxt = E_EXIT;
         E_EXIT:  w_state_nxt = E_RUN;
         default: w_state_nxt = E_RUN;
      endcase
   end

   always_comb begin
      w_scnt_nxt = r_scnt;
      if (commit_v_i)
         w_scnt_nxt = '0;
      else if ((r_state == E_RUN) && (r_scnt != LIMIT))
         w_scnt_nxt = r_scnt + 1'b1;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_state    <= E_RUN;
         r_commit_v <= 1'b0;
         r_dbg      <= 1'b0;
         r_cnt      <= '0;
         r_scnt     <= '0;
         r_stall    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_commit_v <= w_fwd;
         r_dbg      <= (w_state_nxt != E_RUN);
         if (w_fwd)
            r_cnt <= r_cnt + 64'd1;
         r_scnt     <= w_scnt_nxt;
         r_stall    <= (w_scnt_nxt == LIMIT);
      end
   end

   assign commit_v_o      = r_commit_v;
   assign is_debug_mode_o = r_dbg;
   assign commit_cnt_o    = r_cnt;
   assign stall_o         = r_stall;

`ifdef BP_NONSYNTH_COMMIT_WATCHDOG_EN
   logic [vaddr_width_p-1:0] r_last_pc;
   logic                     w_stall_rise;

   assign w_stall_rise = (w_scnt_nxt == LIMIT) & ~r_stall;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)
         r_last_pc <= '0;
      else if (w_fwd)
         r_last_pc <= commit_pc_i;
   end

   always @(posedge clk_i) begin
      if (!reset_i && w_stall_rise) begin
         $display("[BSG-FAIL]: core %x stalled %d cycles, last pc %x",
                  mhartid_i, stall_limit_p, r_last_pc);
         $finish;
      end
   end
`else
   logic w_unused;
   assign w_unused = ^{mhartid_i, commit_pc_i};
`endif

endmodule
